// File: rtl/ledpanel_pkg.sv
// Shared constants, pin map and capture FSM state for the LED panel capture block.
package ledpanel_pkg;

    localparam int PANEL_COLS      = 32;
    localparam int PANEL_HALF_ROWS = 16;
    localparam int PANEL_PLANES    = 8;

    // Bit positions of the panel pins inside the bundled synchronizer bus.
    localparam int PANEL_PINS = 13;
    localparam int PIN_R0  = 0;
    localparam int PIN_G0  = 1;
    localparam int PIN_B0  = 2;
    localparam int PIN_R1  = 3;
    localparam int PIN_G1  = 4;
    localparam int PIN_B1  = 5;
    localparam int PIN_A   = 6;
    localparam int PIN_D   = 9;
    localparam int PIN_CLK = 10;
    localparam int PIN_STB = 11;
    localparam int PIN_OE  = 12;

    // Idle level of the pins: everything low except OE, which is active low.
    // Resetting the synchronizer to this keeps reset from looking like an OE pulse.
    localparam logic [PANEL_PINS-1:0] PIN_IDLE = 13'h1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WRITE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/ledpanel_input_sync.sv
// Multi-stage synchronizer for the bundled panel pins plus registered rising-edge
// detection of CLK, STB and OE. o_pins is delayed one extra stage so that it lines
// up with the edge pulses: when a rise pulse is high, o_pins holds the sample in
// which that signal was first seen high.
module ledpanel_input_sync #(
    parameter int             DEPTH    = 2,
    parameter int             W        = 13,
    parameter logic [W-1:0]   IDLE_VAL = '0,
    parameter int             CLK_BIT  = 10,
    parameter int             STB_BIT  = 11,
    parameter int             OE_BIT   = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_pins,
    output logic [W-1:0] o_pins,
    output logic         o_clk_rise,
    output logic         o_stb_rise,
    output logic         o_oe_rise
);

    logic [W-1:0] r_chain [DEPTH];
    logic [W-1:0] r_prev;
    logic         r_clk_rise;
    logic         r_stb_rise;
    logic         r_oe_rise;
    logic [W-1:0] w_sync;

    assign w_sync = r_chain[DEPTH-1];

    // Same-depth flop chain for every pin keeps data, CLK and STB aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_chain[i] <= IDLE_VAL;
        end else begin
            r_chain[0] <= i_pins;
            for (int i = 1; i < DEPTH; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    // Registered rising-edge pulses, aligned with the delayed pin copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= IDLE_VAL;
            r_clk_rise <= 1'b0;
            r_stb_rise <= 1'b0;
            r_oe_rise  <= 1'b0;
        end else begin
            r_prev     <= w_sync;
            r_clk_rise <= w_sync[CLK_BIT] & ~r_prev[CLK_BIT];
            r_stb_rise <= w_sync[STB_BIT] & ~r_prev[STB_BIT];
            r_oe_rise  <= w_sync[OE_BIT]  & ~r_prev[OE_BIT];
        end
    end

    assign o_pins     = r_prev;
    assign o_clk_rise = r_clk_rise;
    assign o_stb_rise = r_stb_rise;
    assign o_oe_rise  = r_oe_rise;

endmodule

// File: rtl/ledpanel_capture.sv
// HUB75-style panel receiver: rebuilds the 32x32 24-bit image from the panel pins
// into eight bit-plane memories, with a registered read port and status outputs.
module ledpanel_capture
    import ledpanel_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OE_CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PANEL_R0,
    input  logic                PANEL_G0,
    input  logic                PANEL_B0,
    input  logic                PANEL_R1,
    input  logic                PANEL_G1,
    input  logic                PANEL_B1,
    input  logic                PANEL_A,
    input  logic                PANEL_B,
    input  logic                PANEL_C,
    input  logic                PANEL_D,
    input  logic                PANEL_CLK,
    input  logic                PANEL_STB,
    input  logic                PANEL_OE,
    input  logic [4:0]          rd_addr_x,
    input  logic [4:0]          rd_addr_y,
    output logic [23:0]         rd_rgb_data,
    output logic                row_done,
    output logic                frame_done,
    output logic [OE_CNT_W-1:0] oe_cycles,
    output logic                overrun
);

    localparam int MEM_DEPTH = PANEL_COLS * PANEL_HALF_ROWS * 2;
    localparam int LAST_IDX  = 2 * PANEL_COLS - 1;

    logic [PANEL_PINS-1:0] w_pins_in;
    logic [PANEL_PINS-1:0] w_pins;
    logic                  w_clk_rise;
    logic                  w_stb_rise;
    logic                  w_oe_rise;
    logic                  w_unused_pins;

    assign w_pins_in = {PANEL_OE, PANEL_STB, PANEL_CLK, PANEL_D, PANEL_C, PANEL_B, PANEL_A,
                        PANEL_B1, PANEL_G1, PANEL_R1, PANEL_B0, PANEL_G0, PANEL_R0};

    ledpanel_input_sync #(
        .DEPTH    (SYNC_STAGES),
        .W        (PANEL_PINS),
        .IDLE_VAL (PIN_IDLE),
        .CLK_BIT  (PIN_CLK),
        .STB_BIT  (PIN_STB),
        .OE_BIT   (PIN_OE)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_pins     (w_pins_in),
        .o_pins     (w_pins),
        .o_clk_rise (w_clk_rise),
        .o_stb_rise (w_stb_rise),
        .o_oe_rise  (w_oe_rise)
    );

    // CLK and STB are consumed only through their edge pulses.
    assign w_unused_pins = w_pins[PIN_CLK] ^ w_pins[PIN_STB];

    logic [2:0] w_rgb_top;
    logic [2:0] w_rgb_bot;
    logic [3:0] w_row_sel;

    assign w_rgb_top = {w_pins[PIN_R0], w_pins[PIN_G0], w_pins[PIN_B0]};
    assign w_rgb_bot = {w_pins[PIN_R1], w_pins[PIN_G1], w_pins[PIN_B1]};
    assign w_row_sel = w_pins[PIN_D:PIN_A];

    // Column shift registers: new bits enter at the top, so after 32 shifts the
    // oldest surviving bit sits at index 0 (column 0) and the newest at 31.
    logic [PANEL_COLS-1:0][2:0] r_sr_top;
    logic [PANEL_COLS-1:0][2:0] r_sr_bot;

    // Shift one column of top/bottom RGB on every synced panel clock rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_top <= '0;
            r_sr_bot <= '0;
        end else if (w_clk_rise) begin
            r_sr_top <= {w_rgb_top, r_sr_top[PANEL_COLS-1:1]};
            r_sr_bot <= {w_rgb_bot, r_sr_bot[PANEL_COLS-1:1]};
        end
    end

    // r_row / r_plane are both the target of the current write sequence and the
    // "last row / last plane" used to advance the plane on repeated rows.
    cap_state_e                 r_state;
    logic [5:0]                 r_idx;
    logic [3:0]                 r_row;
    logic [2:0]                 r_plane;
    logic                       r_last_valid;
    logic                       r_row_done;
    logic                       r_frame_done;
    logic                       r_overrun;
    logic [PANEL_COLS-1:0][2:0] r_lat_top;
    logic [PANEL_COLS-1:0][2:0] r_lat_bot;
    logic [2:0]                 w_next_plane;

    assign w_next_plane = (r_last_valid && (w_row_sel == r_row)) ? (r_plane + 3'd1) : 3'd0;

    // Capture sequencer: latch on strobe, resolve row/plane, then write 64 entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_row        <= '0;
            r_plane      <= '0;
            r_last_valid <= 1'b0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_lat_top    <= '0;
            r_lat_bot    <= '0;
        end else begin
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_stb_rise && (r_state != IDLE)) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_stb_rise) begin
                        r_lat_top <= r_sr_top;
                        r_lat_bot <= r_sr_bot;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    // Row pins are taken one cycle after the strobe edge because
                    // the driver changes them together with STB.
                    r_row        <= w_row_sel;
                    r_plane      <= w_next_plane;
                    r_last_valid <= 1'b1;
                    r_idx        <= '0;
                    r_state      <= WRITE;
                end
                WRITE: begin
                    r_idx <= r_idx + 6'd1;
                    if (r_idx == 6'(LAST_IDX)) begin
                        r_row_done   <= 1'b1;
                        r_frame_done <= (r_row == 4'(PANEL_HALF_ROWS - 1)) &&
                                        (r_plane == 3'(PANEL_PLANES - 1));
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write port shared by all planes; idx[5] selects top or bottom half.
    logic       w_we;
    logic [4:0] w_wr_col;
    logic [4:0] w_wr_y;
    logic [9:0] w_wr_addr;
    logic [2:0] w_wr_data;
    logic [9:0] w_rd_addr;

    assign w_we      = (r_state == WRITE);
    assign w_wr_col  = r_idx[4:0];
    assign w_wr_y    = {r_idx[5], r_row};
    assign w_wr_addr = {w_wr_col, w_wr_y};
    assign w_wr_data = r_idx[5] ? r_lat_bot[w_wr_col] : r_lat_top[w_wr_col];
    assign w_rd_addr = {rd_addr_x, rd_addr_y};

    logic [PANEL_PLANES-1:0] w_r_bits;
    logic [PANEL_PLANES-1:0] w_g_bits;
    logic [PANEL_PLANES-1:0] w_b_bits;

    genvar gi;
    generate
        for (gi = 0; gi < PANEL_PLANES; gi++) begin : g_plane
            logic [2:0] r_mem [MEM_DEPTH];
            logic [2:0] r_rd;

            // One bit-plane: written only when selected, read every cycle.
            always_ff @(posedge clk) begin
                if (w_we && (r_plane == 3'(gi))) r_mem[w_wr_addr] <= w_wr_data;
                r_rd <= r_mem[w_rd_addr];
            end

            assign w_r_bits[gi] = r_rd[2];
            assign w_g_bits[gi] = r_rd[1];
            assign w_b_bits[gi] = r_rd[0];
        end
    endgenerate

    assign rd_rgb_data = {w_r_bits, w_g_bits, w_b_bits};

    logic [OE_CNT_W-1:0] r_oe_cnt;
    logic [OE_CNT_W-1:0] r_oe_cycles;

    // Saturating OE-low counter, published and cleared on each OE rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_oe_cnt    <= '0;
            r_oe_cycles <= '0;
        end else if (w_oe_rise) begin
            r_oe_cycles <= r_oe_cnt;
            r_oe_cnt    <= '0;
        end else if (!w_pins[PIN_OE] && (r_oe_cnt != '1)) begin
            r_oe_cnt <= r_oe_cnt + OE_CNT_W'(1);
        end
    end

    assign row_done   = r_row_done;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign oe_cycles  = r_oe_cycles;

endmodule

// File: tb/tb_ledpanel_capture.sv
// Scoreboard bench for ledpanel_capture: stimulus pushes expected read data into a
// queue, a monitor pops and compares whenever a read result is presented.
module tb_ledpanel_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        r0, g0, b0, r1, g1, b1;
    logic        pa, pb, pc, pd;
    logic        pclk, pstb, poe;
    logic [4:0]  rd_x, rd_y;
    logic [23:0] rd_rgb;
    logic        row_done, frame_done, overrun;
    logic [15:0] oe_cycles;

    ledpanel_capture #(.SYNC_STAGES(2), .OE_CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .PANEL_R0    (r0),
        .PANEL_G0    (g0),
        .PANEL_B0    (b0),
        .PANEL_R1    (r1),
        .PANEL_G1    (g1),
        .PANEL_B1    (b1),
        .PANEL_A     (pa),
        .PANEL_B     (pb),
        .PANEL_C     (pc),
        .PANEL_D     (pd),
        .PANEL_CLK   (pclk),
        .PANEL_STB   (pstb),
        .PANEL_OE    (poe),
        .rd_addr_x   (rd_x),
        .rd_addr_y   (rd_y),
        .rd_rgb_data (rd_rgb),
        .row_done    (row_done),
        .frame_done  (frame_done),
        .oe_cycles   (oe_cycles),
        .overrun     (overrun)
    );

    int checks = 0;
    int failures = 0;
    int row_done_cnt = 0;
    int frame_done_cnt = 0;

    typedef struct {
        logic [23:0] exp;
        int          x;
        int          y;
    } rd_t;
    rd_t  rd_q[$];
    logic rd_issue = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts status pulses and checks every presented read result.
    initial begin
        logic issued;
        rd_t  e;
        forever begin
            @(posedge clk);
            issued = rd_issue;
            #1;
            if (row_done === 1'b1) row_done_cnt++;
            if (frame_done === 1'b1) begin
                frame_done_cnt++;
                check("frame_done_with_row_done", {31'd0, row_done}, 32'd1);
            end
            if (issued) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got %0h expected none", rd_rgb);
                end else begin
                    e = rd_q.pop_front();
                    check($sformatf("rd(%0d,%0d)", e.x, e.y), {8'd0, rd_rgb}, {8'd0, e.exp});
                    $display("read (%0d,%0d) = %06h", e.x, e.y, rd_rgb);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic [2:0] top, input logic [2:0] bot);
        {r0, g0, b0} = top;
        {r1, g1, b1} = bot;
        pclk = 1'b0;
        tick(1);
        pclk = 1'b1;
        tick(1);
    endtask

    // pre extra zero shifts first, then columns 0..31 (bit c of each vector).
    task automatic send_row(input logic [31:0] vr0, input logic [31:0] vg0, input logic [31:0] vb0,
                            input logic [31:0] vr1, input logic [31:0] vg1, input logic [31:0] vb1,
                            input logic [3:0] row, input int pre);
        for (int i = 0; i < pre; i++) shift_bit(3'b000, 3'b000);
        for (int c = 0; c < 32; c++) shift_bit({vr0[c], vg0[c], vb0[c]}, {vr1[c], vg1[c], vb1[c]});
        pclk = 1'b0;
        strobe(row);
        tick(8);
    endtask

    task automatic strobe(input logic [3:0] row);
        {pd, pc, pb, pa} = row;
        pstb = 1'b1;
        tick(2);
        pstb = 1'b0;
    endtask

    task automatic read_px(input int x, input int y, input logic [23:0] exp);
        rd_t e;
        e.exp = exp;
        e.x   = x;
        e.y   = y;
        rd_q.push_back(e);
        rd_x = 5'(x);
        rd_y = 5'(y);
        rd_issue = 1'b1;
        tick(1);
        rd_issue = 1'b0;
    endtask

    function automatic logic [23:0] grad(input int x, input int y);
        logic [7:0] rr, gg, bb;
        rr = 8'(x * 8);
        gg = 8'(y * 8);
        bb = 8'(255 - x);
        return {rr, gg, bb};
    endfunction

    // ch: 2=R, 1=G, 0=B; bit c = bit p of channel ch of gradient pixel (c, y).
    function automatic logic [31:0] plane_vec(input int ch, input int y, input int p);
        logic [31:0] v;
        logic [23:0] px;
        v = '0;
        for (int c = 0; c < 32; c++) begin
            px   = grad(c, y);
            v[c] = px[ch * 8 + p];
        end
        return v;
    endfunction

    int rd0, fd0;
    logic [31:0] ones32;
    logic [31:0] zero32;

    initial begin
        ones32 = '1;
        zero32 = '0;
        reset = 1'b1;
        {r0, g0, b0, r1, g1, b1} = '0;
        {pa, pb, pc, pd} = '0;
        pclk = 1'b0;
        pstb = 1'b0;
        poe  = 1'b1;
        rd_x = '0;
        rd_y = '0;
        tick(4);
        reset = 1'b0;
        tick(2);

        check("reset_row_done",   {31'd0, row_done},   32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_overrun",    {31'd0, overrun},    32'd0);
        check("reset_oe_cycles",  {16'd0, oe_cycles},  32'd0);

        // Full gradient frame, row-major, planes 0..7 per row.
        rd0 = row_done_cnt;
        fd0 = frame_done_cnt;
        for (int row = 0; row < 16; row++) begin
            for (int p = 0; p < 8; p++) begin
                send_row(plane_vec(2, row, p), plane_vec(1, row, p), plane_vec(0, row, p),
                         plane_vec(2, row + 16, p), plane_vec(1, row + 16, p), plane_vec(0, row + 16, p),
                         4'(row), 0);
            end
        end
        tick(80);
        check("frame_row_done_count", 32'(row_done_cnt - rd0), 32'd128);
        check("frame_done_once",      32'(frame_done_cnt - fd0), 32'd1);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                read_px(x, y, grad(x, y));
        tick(2);

        // Row 7 eight times: top repeats the gradient, bottom is ones in plane 7 only.
        rd0 = row_done_cnt;
        fd0 = frame_done_cnt;
        for (int p = 0; p < 8; p++) begin
            send_row(plane_vec(2, 7, p), plane_vec(1, 7, p), plane_vec(0, 7, p),
                     (p == 7) ? ones32 : zero32, (p == 7) ? ones32 : zero32,
                     (p == 7) ? ones32 : zero32, 4'd7, 0);
        end
        tick(80);
        check("row7_row_done_count", 32'(row_done_cnt - rd0), 32'd8);
        check("row7_no_frame_done",  32'(frame_done_cnt - fd0), 32'd0);
        for (int x = 0; x < 32; x++) read_px(x, 23, 24'h808080);
        for (int x = 0; x < 32; x++) read_px(x, 7, grad(x, 7));
        tick(2);

        // Row 3: clear all eight planes, then 34 shifts with only column 5 top-R set.
        for (int p = 0; p < 8; p++) send_row('0, '0, '0, '0, '0, '0, 4'd3, 0);
        send_row(32'h0000_0020, '0, '0, '0, '0, '0, 4'd3, 2);
        tick(80);
        read_px(5, 3,  24'h010000);
        read_px(5, 19, 24'h000000);
        read_px(4, 3,  24'h000000);
        read_px(6, 3,  24'h000000);
        tick(2);

        // Second strobe 40 clk after the first: overrun, single row_done, sticky.
        check("overrun_before", {31'd0, overrun}, 32'd0);
        rd0 = row_done_cnt;
        for (int c = 0; c < 32; c++) shift_bit(3'b000, 3'b000);
        pclk = 1'b0;
        strobe(4'd11);
        tick(38);
        strobe(4'd11);
        tick(80);
        check("overrun_set",          {31'd0, overrun}, 32'd1);
        check("overrun_one_row_done", 32'(row_done_cnt - rd0), 32'd1);
        tick(100);
        check("overrun_sticky",       {31'd0, overrun}, 32'd1);

        // Reset mid-WRITE: row 9 once (plane 0), again (plane 1) aborted at idx ~20.
        rd0 = row_done_cnt;
        send_row('0, '0, '0, '0, '0, '0, 4'd9, 0);
        tick(80);
        for (int c = 0; c < 32; c++) shift_bit(3'b000, 3'b000);
        pclk = 1'b0;
        strobe(4'd9);
        tick(22);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(80);
        check("abort_no_row_done",    32'(row_done_cnt - rd0), 32'd1);
        check("abort_overrun_clear",  {31'd0, overrun}, 32'd0);
        send_row(ones32, ones32, ones32, '0, '0, '0, 4'd9, 0);
        tick(80);
        check("after_abort_row_done", 32'(row_done_cnt - rd0), 32'd2);
        check("after_abort_overrun",  {31'd0, overrun}, 32'd0);
        read_px(31, 9,  grad(31, 9) | 24'h010101);
        read_px(31, 25, grad(31, 25) & ~24'h010101);
        tick(2);

        // OE low-time measurement and saturation.
        poe = 1'b0;
        tick(17);
        poe = 1'b1;
        tick(8);
        check("oe_17", {16'd0, oe_cycles}, 32'd17);
        poe = 1'b0;
        tick(100);
        check("oe_hold_during_low", {16'd0, oe_cycles}, 32'd17);
        tick(69900);
        poe = 1'b1;
        tick(8);
        check("oe_saturate", {16'd0, oe_cycles}, 32'h0000FFFF);

        tick(4);
        check("scoreboard_empty", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ledpanel_capture.md
# ledpanel_capture

Receiving end of the HUB75-style LED panel interface: samples the panel pins (row select, serial RGB data, shift clock, strobe, output enable) and rebuilds the displayed image as a 32×32, 24-bit frame buffer. It sits on the far side of the panel driver, serving as a panel model for system benches and as an on-board loopback monitor. Frame contents are readable through a registered read port. Status outputs report row/frame completion, OE-low duration and overruns.

## Interface
- SYNC_STAGES, 2, synchronizer depth applied identically to all PANEL_* inputs
- OE_CNT_W, 16, width of the OE-low duration counter
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- PANEL_R0, PANEL_G0, PANEL_B0  in  1 each  serial data, top half (rows 0–15)
- PANEL_R1, PANEL_G1, PANEL_B1  in  1 each  serial data, bottom half (rows 16–31)
- PANEL_A, PANEL_B, PANEL_C, PANEL_D  in  1 each  row select, D = MSB
- PANEL_CLK  in  1  shift clock; data sampled on its rising edge
- PANEL_STB  in  1  latch strobe, active high
- PANEL_OE  in  1  output enable, active low
- rd_addr_x  in  5  read column
- rd_addr_y  in  5  read row
- rd_rgb_data  out  24  {R[7:0],G[7:0],B[7:0]} at {rd_addr_x, rd_addr_y}
- row_done  out  1  one-cycle pulse when a latched bit-plane is fully written
- frame_done  out  1  one-cycle pulse coincident with row_done for row 15, plane 7
- oe_cycles  out  OE_CNT_W  length in clk cycles of the most recent OE-low period, saturating
- overrun  out  1  sticky; set when a strobe arrives while the sequencer is busy

## Operation
- All PANEL_* inputs pass through the same SYNC_STAGES-deep flop chain, so the relative timing of data, CLK and STB is preserved.
- Rising-edge detect on synced CLK:
  - shift {R1,G1,B1} into the 32×3 shift register sr_bot;
  - shift {R0,G0,B0} into sr_top.
  - Only the last 32 shifts before STB count. The 32nd-from-last shifted bit is column 0; the last is column 31.
- Rising edge of synced STB with state IDLE: copy sr_top/sr_bot into latch registers, go to ADDR.
- Rising edge of synced STB with state not IDLE: set overrun and drop the strobe; latch contents are untouched.
- FSM:
  - IDLE: wait for a strobe.
  - ADDR (1 cycle): row = synced {D,C,B,A}, sampled the cycle after the STB edge, because the driver updates the row address with STB. Plane rule: if last_valid and row == last_row, then plane = last_plane+1 mod 8, else plane = 0. Update last_row, last_plane, last_valid := 1. Go to WRITE.
  - WRITE (64 cycles, idx 0..63): col = idx[4:0]; idx[5]=0 writes the top half at y = row, idx[5]=1 writes the bottom half at y = row+16. Each cycle writes the 3-bit {r,g,b} entry at address {col, y} of plane array [plane]. At idx 63, pulse row_done (and frame_done if row==15 && plane==7) and return to IDLE.
- Memory: 8 plane arrays, each 1024×3, one write port each. Only the selected plane is written.
- Read: all 8 arrays are read in parallel at {rd_addr_x, rd_addr_y}. rd_rgb_data bit R[p] comes from plane p, likewise G and B.
- OE counter:
  - counts clk cycles while synced OE is low, saturating at all-ones;
  - on the OE rising edge, transfers the count to oe_cycles and clears.
- Memory is not reset; contents after reset are undefined until written.

## Timing
- Reset values: state IDLE, last_valid 0, row_done 0, frame_done 0, overrun 0, oe_cycles 0, shift/latch registers 0. rd_rgb_data is registered and undefined until the first read after reset.
- Read latency: 1 clk from address to rd_rgb_data. A read of an entry being written in the same cycle returns the old data.
- STB edge to first memory write: SYNC_STAGES + 2 clk. STB edge to row_done: SYNC_STAGES + 66 clk.
- Minimum strobe spacing without overrun: 67 clk. The driver's 74-clk minimum row period satisfies this.
- PANEL_CLK high and low phases must each last ≥1 clk, with data stable across the CLK rising edge.
- Reset mid-WRITE aborts the sequence without a row_done pulse; partially written entries remain in memory.
- A STB edge in the same cycle that WRITE finishes counts as busy and raises overrun.

## Structure
- Package ledpanel_pkg holds:
  - constants PANEL_COLS=32, PANEL_HALF_ROWS=16, PANEL_PLANES=8;
  - the capture FSM state enum (IDLE, ADDR, WRITE).
- Sub-module ledpanel_input_sync: parameterized-depth synchronizer plus registered rising-edge detection for CLK, STB and OE. Instantiated once for the bundled 13 pins.

## Test plan
- Shift 34 clocks with only column 5 top-R = 1, STB, row 3, one strobe: after row_done, read (5,3) = 24'h010000; (5,19), (4,3) and (6,3) = 0.
- Eight consecutive strobes on row 7, all bits 1 for plane 7 only, bottom half only: read (0..31, 23) = 24'h808080; row 7 top unchanged.
- Full driver-model frame with a gradient (x·8, y·8, 255−x): after frame_done, all 1024 pixels match, and frame_done fires exactly once.
- Second STB 40 clk after the first: overrun = 1, only one row_done pulse, and it stays set until reset.
- Hold OE low for 17 clk, then high: oe_cycles = 17. Hold OE low for 70000 clk: oe_cycles = 16'hFFFF.
- Assert reset at WRITE idx 20: no row_done; afterwards state is IDLE, overrun 0, and the next strobe starts at plane 0.
